scan_run_controller: RTL and testbench

SCAN_RUN_CONTROLLER -- requirements
Module: scan_run_controller

---
 rtl/scan_run_controller.sv | 157 +++++++++++++++
 tb/tb_scan_run_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_run_controller.sv
// Scan-chain load-and-run controller.
// A session shifts a host-supplied bit stream into the processor scan chain,
// then enables the processor until it halts, a single step completes, or
// the latched cycle limit is reached. Abort or reset ends any session at once.
module scan_run_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        step_mode,
    input  logic [7:0]  chain_len,
    input  logic [15:0] cycle_limit,
    input  logic        host_bit,
    input  logic        host_valid,
    output logic        host_ready,
    output logic        out_bit,
    output logic        out_valid,
    output logic        scan_enable,
    output logic        scan_in,
    input  logic        scan_out,
    output logic        processor_enable,
    input  logic        processor_halted,
    output logic        busy,
    output logic        done,
    output logic        halted_flag,
    output logic        timeout_flag,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] limit_q, limit_d;
    logic        step_q, step_d;
    logic [7:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;

    logic        transfer;
    logic [7:0]  bit_cnt_inc;
    logic [15:0] cycle_inc;

    // Handshake decode: abort wins over any transfer offered in the same cycle.
    always_comb begin
        transfer    = (state_q == ST_SHIFT) && host_valid && !abort;
        bit_cnt_inc = bit_cnt_q + 8'd1;
        cycle_inc   = (cycle_count_q == 16'hFFFF) ? 16'hFFFF : cycle_count_q + 16'd1;
    end

    // Next-state logic for the session FSM and its session registers.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        len_d         = len_q;
        limit_d       = limit_q;
        step_d        = step_q;
        bit_cnt_d     = bit_cnt_q;
        cycle_count_d = cycle_count_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    len_d         = chain_len;
                    limit_d       = cycle_limit;
                    step_d        = step_mode;
                    bit_cnt_d     = 8'd0;
                    cycle_count_d = 16'd0;
                    halted_d      = 1'b0;
                    timeout_d     = 1'b0;
                    state_d       = (chain_len == 8'd0) ? ST_RUN : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (transfer) begin
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == len_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cycle_count_d = cycle_inc;
                    // A halt outranks both single-step completion and the limit.
                    if (processor_halted) begin
                        halted_d = 1'b1;
                        state_d  = ST_DONE;
                    end else if (step_q) begin
                        state_d = ST_DONE;
                    end else if ((limit_q != 16'd0) && (cycle_inc == limit_q)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and session registers; reset returns everything to idle/zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            len_q         <= 8'd0;
            limit_q       <= 16'd0;
            step_q        <= 1'b0;
            bit_cnt_q     <= 8'd0;
            cycle_count_q <= 16'd0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            len_q         <= len_d;
            limit_q       <= limit_d;
            step_q        <= step_d;
            bit_cnt_q     <= bit_cnt_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
        end
    end

    // Outputs are decoded from state so reset drops them in the same cycle.
    always_comb begin
        host_ready       = (state_q == ST_SHIFT) && !abort;
        scan_enable      = transfer;
        scan_in          = transfer & host_bit;
        out_valid        = transfer;
        out_bit          = transfer & scan_out;
        processor_enable = (state_q == ST_RUN);
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_DONE);
        halted_flag      = halted_q;
        timeout_flag     = timeout_q;
        cycle_count      = cycle_count_q;
    end

endmodule

// File: tb/tb_scan_run_controller.sv
// Directed testbench for scan_run_controller.
module tb_scan_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, step_mode;
    logic [7:0]  chain_len;
    logic [15:0] cycle_limit;
    logic        host_bit, host_valid, host_ready;
    logic        out_bit, out_valid;
    logic        scan_enable, scan_in, scan_out;
    logic        processor_enable, processor_halted;
    logic        busy, done, halted_flag, timeout_flag;
    logic [15:0] cycle_count;

    int checks = 0;
    int fails  = 0;
    int scan_pulses, pe_cycles, done_pulses;

    scan_run_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode),
        .chain_len(chain_len), .cycle_limit(cycle_limit),
        .host_bit(host_bit), .host_valid(host_valid), .host_ready(host_ready),
        .out_bit(out_bit), .out_valid(out_valid),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .processor_enable(processor_enable), .processor_halted(processor_halted),
        .busy(busy), .done(done), .halted_flag(halted_flag),
        .timeout_flag(timeout_flag), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Count pulse-type outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (scan_enable)      scan_pulses++;
        if (processor_enable) pe_cycles++;
        if (done)             done_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        scan_pulses = 0;
        pe_cycles   = 0;
        done_pulses = 0;
    endtask

    task automatic start_session(input logic [7:0] len, input logic [15:0] lim, input logic step);
        chain_len   = len;
        cycle_limit = lim;
        step_mode   = step;
        start       = 1'b1;
        cyc();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; abort = 0; step_mode = 0; chain_len = 8'd0; cycle_limit = 16'd0;
        host_bit = 1; host_valid = 1; scan_out = 1; processor_halted = 0;
        repeat (2) cyc();
        checks++;
        if ({busy, done, processor_enable, host_ready, scan_enable, out_valid, scan_in, out_bit} !== 8'b0) begin
            $display("FAIL reset_outputs: got %b required 00000000",
                     {busy, done, processor_enable, host_ready, scan_enable, out_valid, scan_in, out_bit});
            fails++;
        end
        checks++;
        if ({halted_flag, timeout_flag, cycle_count} !== 18'd0) begin
            $display("FAIL reset_status: got %h required 0", {halted_flag, timeout_flag, cycle_count});
            fails++;
        end
        host_valid = 0; host_bit = 0; scan_out = 0;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        logic [5:0] vld  = 6'b100101;   // bit i = cycle i, gaps between transfers
        logic [5:0] bits = 6'b111001;   // transfers carry 1,0,1
        logic [5:0] sout = 6'b010110;   // scan_out on transfers: 0,1,0
        int tcount = 0;
        clear_counts();
        processor_halted = 1'b1;        // must be ignored while shifting
        start_session(8'd3, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            host_valid = vld[i];
            host_bit   = bits[i];
            scan_out   = sout[i];
            #1;
            checks++;
            if (scan_enable !== vld[i] || out_valid !== vld[i] || host_ready !== 1'b1 || processor_enable !== 1'b0) begin
                $display("FAIL load_strobe[%0d]: se=%b ov=%b hr=%b pe=%b required se=ov=%b hr=1 pe=0",
                         i, scan_enable, out_valid, host_ready, processor_enable, vld[i]);
                fails++;
            end
            if (vld[i]) begin
                checks++;
                if (scan_in !== bits[i] || out_bit !== sout[i]) begin
                    $display("FAIL load_data[%0d]: scan_in=%b out_bit=%b required %b %b",
                             tcount, scan_in, out_bit, bits[i], sout[i]);
                    fails++;
                end
                tcount++;
            end
            cyc();
        end
        host_valid = 0;
        processor_halted = 1'b0;
        checks++;
        if (processor_enable !== 1'b1 || host_ready !== 1'b0) begin
            $display("FAIL load_run_entry: pe=%b hr=%b required pe=1 hr=0", processor_enable, host_ready);
            fails++;
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (scan_pulses !== 3 || done_pulses !== 0 || halted_flag !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL load_summary: pulses=%0d done=%0d halted=%b busy=%b required 3 0 0 0",
                     scan_pulses, done_pulses, halted_flag, busy);
            fails++;
        end
    endtask

    task automatic test_halt();
        clear_counts();
        start_session(8'd0, 16'd0, 1'b0);
        repeat (4) cyc();
        processor_halted = 1'b1;
        cyc();
        processor_halted = 1'b0;
        checks++;
        if (done !== 1'b1 || processor_enable !== 1'b0) begin
            $display("FAIL halt_done_state: done=%b pe=%b required 1 0", done, processor_enable);
            fails++;
        end
        wait_idle("halt");
        repeat (2) cyc();
        checks++;
        if (pe_cycles !== 5 || cycle_count !== 16'd5 || done_pulses !== 1) begin
            $display("FAIL halt_counts: pe=%0d count=%0d done=%0d required 5 5 1", pe_cycles, cycle_count, done_pulses);
            fails++;
        end
        checks++;
        if (halted_flag !== 1'b1 || timeout_flag !== 1'b0) begin
            $display("FAIL halt_flags: halted=%b timeout=%b required 1 0", halted_flag, timeout_flag);
            fails++;
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        start_session(8'd0, 16'd4, 1'b0);
        wait_idle("timeout");
        checks++;
        if (pe_cycles !== 4 || cycle_count !== 16'd4 || done_pulses !== 1) begin
            $display("FAIL timeout_counts: pe=%0d count=%0d done=%0d required 4 4 1", pe_cycles, cycle_count, done_pulses);
            fails++;
        end
        checks++;
        if (timeout_flag !== 1'b1 || halted_flag !== 1'b0) begin
            $display("FAIL timeout_flags: timeout=%b halted=%b required 1 0", timeout_flag, halted_flag);
            fails++;
        end
    endtask

    task automatic test_tie();
        clear_counts();
        start_session(8'd0, 16'd2, 1'b0);
        cyc();
        processor_halted = 1'b1;
        cyc();
        processor_halted = 1'b0;
        wait_idle("tie");
        checks++;
        if (halted_flag !== 1'b1 || timeout_flag !== 1'b0 || cycle_count !== 16'd2) begin
            $display("FAIL tie_flags: halted=%b timeout=%b count=%0d required 1 0 2", halted_flag, timeout_flag, cycle_count);
            fails++;
        end
    endtask

    task automatic test_step();
        clear_counts();
        start_session(8'd2, 16'd0, 1'b1);
        host_valid = 1'b1; host_bit = 1'b1;
        cyc();
        host_bit = 1'b0;
        cyc();
        host_valid = 1'b0;
        wait_idle("step");
        checks++;
        if (pe_cycles !== 1 || cycle_count !== 16'd1 || done_pulses !== 1 || scan_pulses !== 2) begin
            $display("FAIL step_counts: pe=%0d count=%0d done=%0d scan=%0d required 1 1 1 2",
                     pe_cycles, cycle_count, done_pulses, scan_pulses);
            fails++;
        end
        checks++;
        if (halted_flag !== 1'b0 || timeout_flag !== 1'b0) begin
            $display("FAIL step_flags: halted=%b timeout=%b required 0 0", halted_flag, timeout_flag);
            fails++;
        end
    endtask

    task automatic test_start_ignored();
        clear_counts();
        start_session(8'd0, 16'd5, 1'b0);
        cyc();
        cycle_limit = 16'd2;            // must not affect the running session
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle("start_ign");
        checks++;
        if (pe_cycles !== 5 || cycle_count !== 16'd5 || timeout_flag !== 1'b1) begin
            $display("FAIL start_ignored: pe=%0d count=%0d timeout=%b required 5 5 1", pe_cycles, cycle_count, timeout_flag);
            fails++;
        end
    endtask

    task automatic test_abort();
        clear_counts();
        start_session(8'd4, 16'd0, 1'b0);
        host_valid = 1'b1; host_bit = 1'b1; scan_out = 1'b1;
        cyc();
        abort = 1'b1; start = 1'b1;
        #1;
        checks++;
        if (scan_enable !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL abort_priority: se=%b ov=%b required 0 0", scan_enable, out_valid);
            fails++;
        end
        cyc();
        abort = 1'b0; start = 1'b0; host_valid = 1'b0; scan_out = 1'b0;
        checks++;
        if (busy !== 1'b0 || host_ready !== 1'b0) begin
            $display("FAIL abort_idle: busy=%b hr=%b required 0 0", busy, host_ready);
            fails++;
        end
        repeat (3) cyc();
        checks++;
        if (done_pulses !== 0 || scan_pulses !== 1 || pe_cycles !== 0 || busy !== 1'b0) begin
            $display("FAIL abort_summary: done=%0d scan=%0d pe=%0d busy=%b required 0 1 0 0",
                     done_pulses, scan_pulses, pe_cycles, busy);
            fails++;
        end
    endtask

    task automatic test_reset_mid_run();
        clear_counts();
        start_session(8'd0, 16'd0, 1'b0);
        cyc();
        checks++;
        if (processor_enable !== 1'b1) begin
            $display("FAIL rst_pre_run: pe=%b required 1", processor_enable);
            fails++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (processor_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin
            $display("FAIL rst_mid_run: pe=%b busy=%b done=%b count=%0d required 0 0 0 0",
                     processor_enable, busy, done, cycle_count);
            fails++;
        end
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
        checks++;
        if (done_pulses !== 0 || busy !== 1'b0) begin
            $display("FAIL rst_no_done: done=%0d busy=%b required 0 0", done_pulses, busy);
            fails++;
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_load();
        test_halt();
        test_timeout();
        test_tie();
        test_step();
        test_start_ignored();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
